// File: rtl/spram_led_pkg.sv
// Shared definitions for the SPRAM-backed LED colour sequencer.
package spram_led_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT0 = 3'd1,
        INIT1 = 3'd2,
        INIT2 = 3'd3,
        INIT3 = 3'd4,
        RUN   = 3'd5
    } state_t;

    localparam logic [2:0] RED   = 3'b001;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLUE  = 3'b100;
    localparam logic [2:0] WHITE = 3'b111;

    // Colour written to SPRAM while in each preload state; word address is the state's slot.
    function automatic logic [2:0] init_colour(input state_t s);
        logic [2:0] c;
        c = '0;
        case (s)
            INIT0:   c = RED;
            INIT1:   c = GREEN;
            INIT2:   c = BLUE;
            INIT3:   c = WHITE;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] init_slot(input state_t s);
        logic [1:0] a;
        a = '0;
        case (s)
            INIT0:   a = 2'd0;
            INIT1:   a = 2'd1;
            INIT2:   a = 2'd2;
            INIT3:   a = 2'd3;
            default: a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/spram_model.sv
// Behavioural single-port RAM equivalent to SB_SPRAM256KA: nibble-masked write, registered read.
module spram_model #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 16
) (
    input  logic                  i_clk,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_din,
    input  logic [DATA_W/4-1:0]   i_maskwren,
    input  logic                  i_wren,
    output logic [DATA_W-1:0]     o_dout
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout;
    logic [DATA_W-1:0] w_bitmask;

    for (genvar g = 0; g < DATA_W / 4; g++) begin : g_mask
        assign w_bitmask[g*4 +: 4] = {4{i_maskwren[g]}};
    end

    // dout holds its previous value during a write cycle.
    always_ff @(posedge i_clk) begin
        if (i_wren) begin
            r_mem[i_addr] <= (r_mem[i_addr] & ~w_bitmask) | (i_din & w_bitmask);
        end else begin
            r_dout <= r_mem[i_addr];
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/spram_led_sequencer.sv
// Preloads four RGB codes into SPRAM after reset, then cycles them onto the LED; also hosts the UART byte mux.
module spram_led_sequencer
    import spram_led_pkg::*;
#(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 16,
    parameter logic [31:0] PERIOD = 32'h1000000,
    parameter int unsigned MUX_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic [2:0]       led,
    input  logic [MUX_W-1:0] mux_a,
    input  logic [MUX_W-1:0] mux_b,
    input  logic             mux_sel,
    output logic [MUX_W-1:0] mux_z
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_counter;
    logic [31:0]         w_counter_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                r_wren;
    logic                w_wren_nxt;
    logic [DATA_W-1:0]   r_din;
    logic [DATA_W-1:0]   w_din_nxt;
    logic [2:0]          r_led;
    logic [2:0]          w_led_nxt;
    logic [DATA_W-1:0]   w_dout;
    logic [DATA_W/4-1:0] w_maskwren;
    logic                w_unused;

    assign w_maskwren = '1;
    assign w_unused   = ^w_dout[DATA_W-1:3];

    assign mux_z = mux_sel ? mux_b : mux_a;

    spram_model #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_spram (
        .i_clk      (clk),
        .i_addr     (r_addr),
        .i_din      (r_din),
        .i_maskwren (w_maskwren),
        .i_wren     (r_wren),
        .o_dout     (w_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= INIT0;
            r_counter <= '0;
            r_addr    <= '0;
            r_wren    <= 1'b0;
            r_din     <= '0;
            r_led     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_counter <= w_counter_nxt;
            r_addr    <= w_addr_nxt;
            r_wren    <= w_wren_nxt;
            r_din     <= w_din_nxt;
            r_led     <= w_led_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_counter_nxt = r_counter;
        w_addr_nxt    = r_addr;
        w_wren_nxt    = 1'b0;
        w_din_nxt     = r_din;
        w_led_nxt     = r_led;

        case (r_state)
            INIT0, INIT1, INIT2, INIT3: begin
                w_wren_nxt = 1'b1;
                w_addr_nxt = ADDR_W'(init_slot(r_state));
                w_din_nxt  = DATA_W'(init_colour(r_state));
                case (r_state)
                    INIT0:   w_state_nxt = INIT1;
                    INIT1:   w_state_nxt = INIT2;
                    INIT2:   w_state_nxt = INIT3;
                    default: w_state_nxt = RUN;
                endcase
            end
            RUN: begin
                w_counter_nxt = r_counter + 32'd1;
                if (r_counter == PERIOD) begin
                    w_addr_nxt      = '0;
                    w_addr_nxt[1:0] = r_addr[1:0] + 2'd1;
                end
                // Two cycles after the address step: one to register addr, one for read latency.
                if (r_counter == PERIOD + 32'd2) begin
                    w_led_nxt     = w_dout[2:0];
                    w_counter_nxt = '0;
                end
            end
            default: w_state_nxt = INIT0;
        endcase
    end

    assign led = r_led;

endmodule

// File: tb/tb_spram_led_sequencer.sv
// Scoreboard bench for spram_led_sequencer with a short LED period.
module tb_spram_led_sequencer;
    import spram_led_pkg::*;

    localparam logic [31:0] P = 32'd8;

    typedef struct packed {
        logic [2:0]  led;
        int unsigned at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] led;
    logic [7:0] mux_a = '0;
    logic [7:0] mux_b = '0;
    logic       mux_sel = 1'b0;
    logic [7:0] mux_z;

    int          checks = 0;
    int          failures = 0;
    int unsigned edge_cnt = 0;
    exp_t        sb[$];
    logic [15:0] exp_word [4] = '{16'h0001, 16'h0002, 16'h0004, 16'h0007};

    always #5 clk = ~clk;

    spram_led_sequencer #(
        .ADDR_W (14),
        .DATA_W (16),
        .PERIOD (P),
        .MUX_W  (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .led     (led),
        .mux_a   (mux_a),
        .mux_b   (mux_b),
        .mux_sel (mux_sel),
        .mux_z   (mux_z)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        edge_cnt = 0;
    endtask

    task automatic push_exp(input logic [2:0] v, input int unsigned at);
        exp_t e;
        e.led = v;
        e.at  = at;
        sb.push_back(e);
    endtask

    task automatic run_scoreboard(input int unsigned limit);
        exp_t       e;
        logic [2:0] prev;
        prev = led;
        while (sb.size() > 0 && edge_cnt < limit) begin
            tick();
            if (led !== prev) begin
                e = sb.pop_front();
                checks++;
                if (led !== e.led || edge_cnt != e.at) begin
                    failures++;
                    $display("FAIL led_seq: got led=%b at edge %0d, expected led=%b at edge %0d",
                             led, edge_cnt, e.led, e.at);
                end
                prev = led;
            end
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL led_timeout: %0d LED updates still pending at edge %0d, expected 0",
                     sb.size(), edge_cnt);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (led !== 3'b000) begin failures++; $display("FAIL reset_led: got %b, expected 000", led); end
        checks++;
        if (dut.r_state !== INIT0) begin failures++; $display("FAIL reset_state: got %0d, expected %0d", dut.r_state, INIT0); end
        checks++;
        if (dut.r_wren !== 1'b0 || dut.r_addr !== 14'd0 || dut.r_din !== 16'd0) begin
            failures++;
            $display("FAIL reset_regs: got wren=%b addr=%0d din=%h, expected 0 0 0000", dut.r_wren, dut.r_addr, dut.r_din);
        end
        checks++;
        if (dut.r_counter !== 32'd0) begin failures++; $display("FAIL reset_counter: got %0d, expected 0", dut.r_counter); end
    endtask

    task automatic test_mux();
        logic [7:0] exp_z;
        rst = 1'b1;
        mux_a = 8'h55;
        mux_b = 8'hAA;
        mux_sel = 1'b0;
        #1;
        checks++;
        if (mux_z !== 8'h55) begin failures++; $display("FAIL mux_sel0: got %h, expected 55", mux_z); end
        mux_sel = 1'b1;
        #1;
        checks++;
        if (mux_z !== 8'hAA) begin failures++; $display("FAIL mux_sel1: got %h, expected aa", mux_z); end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mux_a   = 8'($urandom);
            mux_b   = 8'($urandom);
            mux_sel = 1'($urandom);
            exp_z   = mux_sel ? mux_b : mux_a;
            #1;
            checks++;
            if (mux_z !== exp_z) begin failures++; $display("FAIL mux_rand: got %h, expected %h", mux_z, exp_z); end
        end
    endtask

    task automatic test_init_writes();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (dut.r_wren !== 1'b1 || dut.r_addr !== 14'(i) || dut.r_din !== exp_word[i]) begin
                failures++;
                $display("FAIL init_write%0d: got wren=%b addr=%0d din=%h, expected 1 %0d %h",
                         i, dut.r_wren, dut.r_addr, dut.r_din, i, exp_word[i]);
            end
        end
        tick();
        checks++;
        if (dut.r_wren !== 1'b0 || dut.r_state !== RUN) begin
            failures++;
            $display("FAIL init_done: got wren=%b state=%0d, expected 0 %0d", dut.r_wren, dut.r_state, RUN);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut.u_spram.r_mem[i] !== exp_word[i]) begin
                failures++;
                $display("FAIL init_mem%0d: got %h, expected %h", i, dut.u_spram.r_mem[i], exp_word[i]);
            end
        end
    endtask

    task automatic test_led_cadence();
        do_reset();
        push_exp(RED, 15);
        push_exp(GREEN, 26);
        push_exp(BLUE, 37);
        push_exp(WHITE, 48);
        push_exp(RED, 59);
        run_scoreboard(80);
    endtask

    task automatic test_read_latency();
        logic [1:0] a;
        logic       w;
        do_reset();
        repeat (5) tick();
        for (int i = 0; i < 22; i++) begin
            a = dut.r_addr[1:0];
            w = dut.r_wren;
            tick();
            if (!w) begin
                checks++;
                if (dut.w_dout !== exp_word[a]) begin
                    failures++;
                    $display("FAIL rd_latency: edge %0d got dout=%h, expected %h", edge_cnt, dut.w_dout, exp_word[a]);
                end
            end
            if (edge_cnt == 13) begin
                checks++;
                if (dut.r_addr !== 14'd0) begin failures++; $display("FAIL addr_wrap: got %0d, expected 0", dut.r_addr); end
            end
            if (edge_cnt == 14) begin
                checks++;
                if (led !== 3'b000) begin failures++; $display("FAIL led_early: got %b, expected 000", led); end
            end
            if (edge_cnt == 15) begin
                checks++;
                if (led !== RED) begin failures++; $display("FAIL led_capture: got %b, expected 001", led); end
            end
        end
    endtask

    task automatic test_mid_run_reset();
        do_reset();
        while (led !== BLUE && edge_cnt < 60) tick();
        checks++;
        if (led !== BLUE) begin failures++; $display("FAIL wait_blue: got %b by edge %0d, expected 100", led, edge_cnt); end
        rst = 1'b1;
        tick();
        checks++;
        if (led !== 3'b000 || dut.r_state !== INIT0) begin
            failures++;
            $display("FAIL midrun_rst: got led=%b state=%0d, expected 000 %0d", led, dut.r_state, INIT0);
        end
        rst = 1'b0;
        edge_cnt = 0;
        push_exp(RED, 15);
        push_exp(GREEN, 26);
        run_scoreboard(40);
    endtask

    task automatic test_mem_retention();
        do_reset();
        repeat (20) tick();
        dut.u_spram.r_mem[1] = 16'hFFFF;
        rst = 1'b1;
        tick();
        checks++;
        if (dut.u_spram.r_mem[1] !== 16'hFFFF) begin
            failures++;
            $display("FAIL mem_keep: got %h, expected ffff", dut.u_spram.r_mem[1]);
        end
        rst = 1'b0;
        edge_cnt = 0;
        push_exp(RED, 15);
        push_exp(GREEN, 26);
        run_scoreboard(40);
        checks++;
        if (dut.u_spram.r_mem[1] !== 16'h0002) begin
            failures++;
            $display("FAIL mem_rewrite: got %h, expected 0002", dut.u_spram.r_mem[1]);
        end
    endtask

    initial begin
        test_reset();
        test_mux();
        test_init_writes();
        test_led_cadence();
        test_read_latency();
        test_mid_run_reset();
        test_mem_retention();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
